// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the execute/memory slice.
//   - opcode constants (instruction bits [31:26])
//   - alu_op_e : ALU operation selected by the decoder
//   - ctrl_t   : packed bundle of decoded datapath controls
// Optional feature macro: ALU_SHIFT_EN (adds SLL/SRL opcodes).
package alu_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h06;
  localparam logic [5:0] OP_ORI  = 6'h07;
  localparam logic [5:0] OP_LW   = 6'h08;
  localparam logic [5:0] OP_SW   = 6'h09;
  localparam logic [5:0] OP_BEQ  = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h0B;
  localparam logic [5:0] OP_SLL  = 6'h0C;
  localparam logic [5:0] OP_SRL  = 6'h0D;

  // AluZero is encoded as 0 so an all-zero control word is a clean NOP.
  typedef enum logic [2:0] {
    AluZero = 3'd0,
    AluAdd  = 3'd1,
    AluSub  = 3'd2,
    AluAnd  = 3'd3,
    AluOr   = 3'd4,
    AluSlt  = 3'd5,
    AluSll  = 3'd6,
    AluSrl  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    jump;
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/alu_ctrl_dmem_unit_if.sv
// alu_ctrl_dmem_unit_if: operand/control/debug bundle of the execute/memory slice.
//   master : drives opcode, rs_data, rt_data, imm16, dbg_addr; observes results
//   slave  : the datapath; drives decoded controls, ALU result, flags,
//            write-back value and debug read data
interface alu_ctrl_dmem_unit_if;

  logic [5:0]  opcode;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic [4:0]  dbg_addr;

  logic        reg_dst;
  logic        jump;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] write_data;
  logic [31:0] dbg_data;

  modport master (
    output opcode, rs_data, rt_data, imm16, dbg_addr,
    input  reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    input  alu_result, zero, branch_taken, write_data, dbg_data
  );

  modport slave (
    input  opcode, rs_data, rt_data, imm16, dbg_addr,
    output reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    output alu_result, zero, branch_taken, write_data, dbg_data
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode-to-control decoder.
//   i_opcode : instruction bits [31:26]
//   o_ctrl   : decoded datapath controls and ALU operation
// Optional feature macro: ALU_SHIFT_EN (decodes 0x0C SLL / 0x0D SRL; otherwise NOP).
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NOP;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (i_opcode)
          OP_ADD:  o_ctrl.alu_op = AluAdd;
          OP_SUB:  o_ctrl.alu_op = AluSub;
          OP_AND:  o_ctrl.alu_op = AluAnd;
          OP_OR:   o_ctrl.alu_op = AluOr;
          default: o_ctrl.alu_op = AluSlt;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (i_opcode)
          OP_ADDI: o_ctrl.alu_op = AluAdd;
          OP_ANDI: o_ctrl.alu_op = AluAnd;
          default: o_ctrl.alu_op = AluOr;
        endcase
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_op     = AluAdd;
      end
      OP_SW: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = AluAdd;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = AluSub;
      end
      OP_J: begin
        o_ctrl.jump = 1'b1;
      end
`ifdef ALU_SHIFT_EN
      OP_SLL: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = AluSll;
      end
      OP_SRL: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = AluSrl;
      end
`endif
      default: o_ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_dmem_unit.sv
// alu_ctrl_dmem_unit: execute + memory slice of the single-cycle processor.
//   clk   : memory write clock
//   rst_n : asynchronous active-low reset, clears the data memory
//   bus   : alu_ctrl_dmem_unit_if.slave (operands, opcode, immediate, debug
//           address in; decoded controls, ALU result, zero, branch_taken,
//           write-back value and debug data out)
// Everything except the data-memory store is combinational.
// Optional feature macro: ALU_SHIFT_EN (SLL/SRL ALU operations).
module alu_ctrl_dmem_unit
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_ctrl_dmem_unit_if.slave  bus
);

  localparam int unsigned AddrW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  ctrl_t             w_ctrl;
  logic [31:0]       w_imm_ext;
  logic [31:0]       w_alu_b;
  logic [31:0]       w_alu_result;
  logic [AddrW-1:0]  w_addr;
  logic [31:0]       w_mem_rdata;
  logic [31:0]       r_mem [DMEM_DEPTH];

  alu_ctrl_decode u_decode (
    .i_opcode (bus.opcode),
    .o_ctrl   (w_ctrl)
  );

  assign w_imm_ext = {16'd0, bus.imm16};
  assign w_alu_b   = w_ctrl.alu_src ? w_imm_ext : bus.rt_data;

  always_comb begin
    w_alu_result = '0;
    case (w_ctrl.alu_op)
      AluAdd:  w_alu_result = bus.rs_data + w_alu_b;
      AluSub:  w_alu_result = bus.rs_data - w_alu_b;
      AluAnd:  w_alu_result = bus.rs_data & w_alu_b;
      AluOr:   w_alu_result = bus.rs_data | w_alu_b;
      AluSlt:  w_alu_result = ($signed(bus.rs_data) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      AluSll:  w_alu_result = bus.rs_data << w_alu_b[4:0];
      AluSrl:  w_alu_result = bus.rs_data >> w_alu_b[4:0];
`endif
      default: w_alu_result = '0;
    endcase
  end

  // Upper address bits are dropped, so memory addresses wrap modulo depth.
  assign w_addr      = w_alu_result[AddrW-1:0];
  assign w_mem_rdata = r_mem[w_addr];

  // Async clear wins over any pending store; writes land on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_ctrl.mem_write) begin
      r_mem[w_addr] <= bus.rt_data;
    end
  end

  assign bus.reg_dst      = w_ctrl.reg_dst;
  assign bus.jump         = w_ctrl.jump;
  assign bus.branch       = w_ctrl.branch;
  assign bus.mem_read     = w_ctrl.mem_read;
  assign bus.mem_to_reg   = w_ctrl.mem_to_reg;
  assign bus.mem_write    = w_ctrl.mem_write;
  assign bus.alu_src      = w_ctrl.alu_src;
  assign bus.reg_write    = w_ctrl.reg_write;
  assign bus.alu_result   = w_alu_result;
  assign bus.zero         = (w_alu_result == 32'd0);
  assign bus.branch_taken = w_ctrl.branch & bus.zero;
  assign bus.write_data   = w_ctrl.mem_to_reg ? w_mem_rdata : w_alu_result;
  assign bus.dbg_data     = r_mem[bus.dbg_addr];

endmodule

// File: tb/tb_alu_ctrl_dmem_unit.sv
// tb_alu_ctrl_dmem_unit: directed vectors; each check pushes an expectation
// into a queue and strobes the monitor, which pops and compares DUT outputs.
// Control vector order: {reg_dst, jump, branch, mem_read, mem_to_reg,
// mem_write, alu_src, reg_write}; flag order: {zero, branch_taken}.
module tb_alu_ctrl_dmem_unit;

  typedef struct {
    string       name;
    bit          cc;
    logic [7:0]  ctrl;
    bit          cr;
    logic [31:0] res;
    bit          cw;
    logic [31:0] wd;
    bit          cf;
    logic [1:0]  fl;
    bit          cd;
    logic [31:0] dbg;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sample;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  alu_ctrl_dmem_unit_if bus ();

  alu_ctrl_dmem_unit #(.DMEM_DEPTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(string name, bit cc, logic [7:0] ctrl, bit cr, logic [31:0] res,
                              bit cw, logic [31:0] wd, bit cf, logic [1:0] fl, bit cd,
                              logic [31:0] dbg);
    exp_t e;
    e.name = name; e.cc = cc; e.ctrl = ctrl; e.cr = cr; e.res = res; e.cw = cw; e.wd = wd;
    e.cf = cf; e.fl = fl; e.cd = cd; e.dbg = dbg;
    return e;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [4:0] dbg);
    bus.opcode   = op;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm16    = imm;
    bus.dbg_addr = dbg;
  endtask

  task automatic check(input exp_t e);
    #1;
    exp_q.push_back(e);
    sample = 1'b1;
    #1;
    sample = 1'b0;
  endtask

  // Monitor: compare whatever the popped expectation enables.
  initial begin
    exp_t e;
    logic [7:0] a_ctrl;
    forever begin
      @(posedge sample);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL monitor_underflow: got strobe with empty queue, required an entry");
      end else begin
        e = exp_q.pop_front();
        a_ctrl = {bus.reg_dst, bus.jump, bus.branch, bus.mem_read, bus.mem_to_reg,
                  bus.mem_write, bus.alu_src, bus.reg_write};
        if (e.cc) begin
          compared++;
          if (a_ctrl !== e.ctrl) begin
            mismatched++;
            $display("FAIL %s.ctrl: got %b required %b", e.name, a_ctrl, e.ctrl);
          end
        end
        if (e.cr) begin
          compared++;
          if (bus.alu_result !== e.res) begin
            mismatched++;
            $display("FAIL %s.alu_result: got %h required %h", e.name, bus.alu_result, e.res);
          end
        end
        if (e.cw) begin
          compared++;
          if (bus.write_data !== e.wd) begin
            mismatched++;
            $display("FAIL %s.write_data: got %h required %h", e.name, bus.write_data, e.wd);
          end
        end
        if (e.cf) begin
          compared++;
          if ({bus.zero, bus.branch_taken} !== e.fl) begin
            mismatched++;
            $display("FAIL %s.flags: got %b required %b", e.name,
                     {bus.zero, bus.branch_taken}, e.fl);
          end
        end
        if (e.cd) begin
          compared++;
          if (bus.dbg_data !== e.dbg) begin
            mismatched++;
            $display("FAIL %s.dbg_data: got %h required %h", e.name, bus.dbg_data, e.dbg);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    sample     = 1'b0;
    rst_n      = 1'b0;
    drive(6'h3F, 32'd0, 32'd0, 16'd0, 5'd0);
    #12;
    rst_n = 1'b1;

    // Memory reads zero after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(6'h3F, 32'd0, 32'd0, 16'd0, 5'(i));
      check(ex($sformatf("reset_dbg%0d", i), 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 32'd0));
    end

    @(negedge clk); drive(6'h05, 32'd5, 32'd0, 16'd3, 5'd0);
    check(ex("addi", 1, 8'b0000_0011, 1, 32'd8, 1, 32'd8, 1, 2'b00, 0, 0));

    // Store: old value visible until the edge.
    @(negedge clk); drive(6'h09, 32'd2, 32'hDEADBEEF, 16'd1, 5'd3);
    check(ex("sw_pre", 1, 8'b0000_0110, 1, 32'd3, 0, 0, 0, 2'b00, 1, 32'd0));
    @(posedge clk);
    check(ex("sw_post", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'hDEADBEEF));

    @(negedge clk); drive(6'h08, 32'd2, 32'hDEADBEEF, 16'd1, 5'd3);
    check(ex("lw", 1, 8'b0001_1011, 1, 32'd3, 1, 32'hDEADBEEF, 0, 2'b00, 0, 0));

    @(negedge clk); drive(6'h0A, 32'd7, 32'd7, 16'd0, 5'd0);
    check(ex("beq_eq", 1, 8'b0010_0000, 1, 32'd0, 0, 0, 1, 2'b11, 0, 0));
    @(negedge clk); drive(6'h0A, 32'd7, 32'd8, 16'd0, 5'd0);
    check(ex("beq_ne", 0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 2'b00, 0, 0));

    @(negedge clk); drive(6'h04, 32'hFFFFFFFF, 32'd1, 16'd0, 5'd0);
    check(ex("slt_signed", 1, 8'b1000_0001, 1, 32'd1, 1, 32'd1, 1, 2'b00, 0, 0));
    @(negedge clk); drive(6'h00, 32'hFFFFFFFF, 32'd1, 16'd0, 5'd0);
    check(ex("add_wrap", 1, 8'b1000_0001, 1, 32'd0, 1, 32'd0, 1, 2'b10, 0, 0));
    @(negedge clk); drive(6'h01, 32'd10, 32'd3, 16'd0, 5'd0);
    check(ex("sub", 0, 0, 1, 32'd7, 0, 0, 0, 2'b00, 0, 0));
    @(negedge clk); drive(6'h02, 32'h0000F0F0, 32'h0000FF00, 16'd0, 5'd0);
    check(ex("and", 0, 0, 1, 32'h0000F000, 0, 0, 0, 2'b00, 0, 0));
    @(negedge clk); drive(6'h03, 32'h0000F0F0, 32'h0000FF00, 16'd0, 5'd0);
    check(ex("or", 0, 0, 1, 32'h0000FFF0, 0, 0, 0, 2'b00, 0, 0));
    @(negedge clk); drive(6'h06, 32'hFFFF1234, 32'hFFFFFFFF, 16'h00FF, 5'd0);
    check(ex("andi_zext", 1, 8'b0000_0011, 1, 32'h00000034, 0, 0, 0, 2'b00, 0, 0));
    @(negedge clk); drive(6'h07, 32'h12340000, 32'd0, 16'hABCD, 5'd0);
    check(ex("ori_zext", 0, 0, 1, 32'h1234ABCD, 0, 0, 0, 2'b00, 0, 0));
    @(negedge clk); drive(6'h0B, 32'd9, 32'd4, 16'd5, 5'd0);
    check(ex("jump", 1, 8'b0100_0000, 1, 32'd0, 0, 0, 1, 2'b10, 0, 0));

    @(negedge clk); drive(6'h0C, 32'h00000003, 32'd4, 16'd0, 5'd0);
`ifdef ALU_SHIFT_EN
    check(ex("sll", 1, 8'b1000_0001, 1, 32'h00000030, 0, 0, 0, 2'b00, 0, 0));
`else
    check(ex("op0c_nop", 1, 8'h00, 1, 32'd0, 0, 0, 0, 2'b00, 0, 0));
`endif
    @(negedge clk); drive(6'h0D, 32'h80000000, 32'd4, 16'd0, 5'd0);
`ifdef ALU_SHIFT_EN
    check(ex("srl", 1, 8'b1000_0001, 1, 32'h08000000, 0, 0, 0, 2'b00, 0, 0));
`else
    check(ex("op0d_nop", 1, 8'h00, 1, 32'd0, 0, 0, 0, 2'b00, 0, 0));
`endif

    // Address 33 wraps to word 1.
    @(negedge clk); drive(6'h09, 32'd30, 32'hCAFEF00D, 16'd3, 5'd1);
    check(ex("sw33_pre", 0, 0, 1, 32'd33, 0, 0, 0, 2'b00, 1, 32'd0));
    @(posedge clk);
    check(ex("sw33_post", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'hCAFEF00D));

    // Reset between edges clears immediately and blocks a pending store.
    @(negedge clk); drive(6'h09, 32'd30, 32'h11111111, 16'd3, 5'd1);
    #1;
    rst_n = 1'b0;
    check(ex("rst_clear", 1, 8'b0000_0110, 1, 32'd33, 0, 0, 0, 2'b00, 1, 32'd0));
    @(posedge clk);
    check(ex("rst_blocks_wr", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'd0));
    @(negedge clk); drive(6'h3F, 32'd5, 32'd5, 16'h1234, 5'd3);
    rst_n = 1'b1;
    check(ex("rst_clear_w3", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'd0));
    check(ex("nop_3f", 1, 8'h00, 1, 32'd0, 1, 32'd0, 1, 2'b10, 0, 0));

    // Drain: every expectation must have been consumed.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
